// File: rtl/time_check_pkg.sv
// time_check_pkg: shared state encoding and defaults for the cycle-timing checker blocks
package time_check_pkg;
    localparam int ERR_CNT_W_DEFAULT = 8;
    typedef enum logic [2:0] {
        S_Idle    = 3'd0,
        S_Hold    = 3'd1,
        S_Release = 3'd2,
        S_WaitLow = 3'd3,
        S_Lock    = 3'd4
    } state_t;
endpackage

// File: rtl/time_error_handler_hold_timer.sv
// hold_timer: loadable down-counter that stops at zero
module hold_timer #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    // load wins over decrement; decrement saturates at zero
    always_comb begin
        cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - WIDTH'(1) : cnt_q;
    end
    // count register
    always_ff @(posedge Clk) begin
        cnt_q <= Rst ? '0 : cnt_d;
    end
    assign zero = cnt_q == '0;
endmodule

// File: rtl/time_error_handler.sv
// time_error_handler: counts verifier errors, holds each one, then pulses ErrorRst or locks out
module time_error_handler
    import time_check_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_WIDTH   = ERR_CNT_W_DEFAULT,
    parameter int LOCK_THRESH = 3
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Error,
    input  logic                 Ack,
    input  logic                 Clear,
    output logic                 ErrorRst,
    output logic [CNT_WIDTH-1:0] ErrCount,
    output logic                 Lockout,
    output logic                 Busy
);
    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] LOCK_VAL = CNT_WIDTH'(LOCK_THRESH);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 t_load, t_dec, t_zero;

    hold_timer #(.WIDTH(TW)) u_timer (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (t_load),
        .load_val (HOLD_LOAD),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    // state and error counter registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_Idle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // next state, counter update and timer control; an error is counted only when leaving S_Idle
    always_comb begin
        state_d = state_q;
        cnt_d   = Clear ? '0 : cnt_q;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        case (state_q)
            S_Idle: if (Error) begin
                t_load  = 1'b1;
                cnt_d   = Clear ? CNT_WIDTH'(1) : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                state_d = (LOCK_THRESH != 0 && cnt_d >= LOCK_VAL) ? S_Lock : S_Hold;
            end
            S_Hold: begin
                t_dec   = 1'b1;
                state_d = (t_zero || Ack) ? S_Release : S_Hold;
            end
            S_Release: state_d = S_WaitLow;
            S_WaitLow: state_d = Error ? S_WaitLow : S_Idle;
            S_Lock:    state_d = Clear ? S_Release : S_Lock;
            default:   state_d = S_Idle;
        endcase
    end

    assign ErrorRst = state_q == S_Release;
    assign Lockout  = state_q == S_Lock;
    assign Busy     = state_q != S_Idle;
    assign ErrCount = cnt_q;
endmodule
